// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder: stage 1 registers bit g/p, stage 2 builds carries with bclg4 and registers sum.
// Define CLA_OVF_EN to build the signed-overflow output; without it out_ovf is constant 0.

module bclg4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] c,
    output logic       gout,
    output logic       pout
);
    // c[i] is the carry into bit i of the 4-bit group
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pout = &p;
endmodule

module cla_add_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NG   = WIDTH / 4;
    localparam int TOPC = (NG < 4) ? NG : 3;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_cin;
    logic             s2_free;
    logic             in_xfer;
    logic             s2_load;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign in_xfer  = in_valid && in_ready;
    assign s2_load  = s1_valid && s2_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Operand terms carry no reset: s1_valid alone qualifies them
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_g   <= in_a & in_b;
            s1_p   <= in_a ^ in_b;
            s1_cin <= in_cin;
        end
    end

    logic [3:0]       grp_g;
    logic [3:0]       grp_p;
    logic [3:0]       grp_c;
    logic             top_g;
    logic             top_p;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        if (k < NG) begin : g_used
            bclg4 u_grp (
                .g    (s1_g[4*k +: 4]),
                .p    (s1_p[4*k +: 4]),
                .cin  (grp_c[k]),
                .c    (c[4*k +: 4]),
                .gout (grp_g[k]),
                .pout (grp_p[k])
            );
        end else begin : g_unused
            assign grp_g[k] = 1'b0;
            assign grp_p[k] = 1'b0;
        end
    end

    bclg4 u_top (
        .g    (grp_g),
        .p    (grp_p),
        .cin  (s1_cin),
        .c    (grp_c),
        .gout (top_g),
        .pout (top_p)
    );

    // With fewer than four groups the zeroed upper lanes kill top gout/pout,
    // so the carry out is the lookahead carry into the first unused lane.
    if (NG == 4) begin : g_cout_full
        assign s2_cout = top_g | (top_p & s1_cin);
    end else begin : g_cout_part
        assign s2_cout = grp_c[TOPC];
    end

    assign s2_sum = s1_p ^ c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_sum   <= s2_sum;
            out_cout  <= s2_cout;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CLA_OVF_EN
    logic s1_amsb;
    logic s1_bmsb;
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            s1_amsb <= in_a[WIDTH-1];
            s1_bmsb <= in_b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s2_load) begin
            ovf_q <= (s1_amsb == s1_bmsb) && (s2_sum[WIDTH-1] != s1_amsb);
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_add_pipe.sv
// Bench for cla_add_pipe: directed scenarios on WIDTH=16 plus randomized handshake traffic on WIDTH=4/8/12/16 in parallel.
module tb_cla_add_pipe;

`ifdef CLA_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;

    logic [3:0]  rdy_v;
    logic [3:0]  vld_v;
    logic [3:0]  cout_v;
    logic [3:0]  ovf_v;
    logic [3:0]  sum4;
    logic [7:0]  sum8;
    logic [11:0] sum12;
    logic [15:0] sum16;
    logic [18:0] obs [4];

    int n_pass  = 0;
    int n_total = 0;
    int wid [4] = '{4, 8, 12, 16};

    always #5 clk = ~clk;

    cla_add_pipe #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[0]),
        .in_a(a[3:0]), .in_b(b[3:0]), .in_cin(cin), .out_valid(vld_v[0]),
        .out_ready(out_ready), .out_sum(sum4), .out_cout(cout_v[0]), .out_ovf(ovf_v[0]));
    cla_add_pipe #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[1]),
        .in_a(a[7:0]), .in_b(b[7:0]), .in_cin(cin), .out_valid(vld_v[1]),
        .out_ready(out_ready), .out_sum(sum8), .out_cout(cout_v[1]), .out_ovf(ovf_v[1]));
    cla_add_pipe #(.WIDTH(12)) u_w12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[2]),
        .in_a(a[11:0]), .in_b(b[11:0]), .in_cin(cin), .out_valid(vld_v[2]),
        .out_ready(out_ready), .out_sum(sum12), .out_cout(cout_v[2]), .out_ovf(ovf_v[2]));
    cla_add_pipe #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[3]),
        .in_a(a), .in_b(b), .in_cin(cin), .out_valid(vld_v[3]),
        .out_ready(out_ready), .out_sum(sum16), .out_cout(cout_v[3]), .out_ovf(ovf_v[3]));

    assign obs[0] = {vld_v[0], ovf_v[0], cout_v[0], 12'b0, sum4};
    assign obs[1] = {vld_v[1], ovf_v[1], cout_v[1], 8'b0, sum8};
    assign obs[2] = {vld_v[2], ovf_v[2], cout_v[2], 4'b0, sum12};
    assign obs[3] = {vld_v[3], ovf_v[3], cout_v[3], sum16};

    // Reference: {valid, ovf, cout, sum} from integer and signed-range arithmetic
    function automatic logic [18:0] ref_add(input int w, input logic [15:0] ra, input logic [15:0] rb,
                                            input logic rc);
        longint m, half, ua, ub, full, sa, sb, ss;
        logic   ov, co;
        logic [15:0] s;
        m    = (longint'(1) << w) - 1;
        half = (m + 1) / 2;
        ua   = longint'(ra) & m;
        ub   = longint'(rb) & m;
        full = ua + ub + longint'(rc);
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        ss   = sa + sb + longint'(rc);
        ov   = OVF_ON && ((ss > half - 1) || (ss < -half));
        co   = ((full >> w) & 1) != 0;
        s    = 16'(full & m);
        return {1'b1, ov, co, s};
    endfunction

    task automatic pulse_one(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
        @(negedge clk);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 16'(($urandom)); b = 16'(($urandom)); cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_total++;
        if (vld_v !== 4'h0) $display("FAIL reset_valid: got %b want 0000", vld_v); else n_pass++;
        n_total++;
        if (sum16 !== 16'h0) $display("FAIL reset_sum: got %h want 0000", sum16); else n_pass++;
        n_total++;
        if (cout_v !== 4'h0) $display("FAIL reset_cout: got %b want 0000", cout_v); else n_pass++;
        n_total++;
        if (ovf_v !== 4'h0) $display("FAIL reset_ovf: got %b want 0000", ovf_v); else n_pass++;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk); #1;
        n_total++;
        if (rdy_v !== 4'hF) $display("FAIL reset_in_ready: got %b want 1111", rdy_v); else n_pass++;
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; #1;
        n_total++;
        if (vld_v[3] !== 1'b0) $display("FAIL single_early_valid: got %b want 0", vld_v[3]); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (obs[3] !== {1'b1, 1'b0, 1'b0, 16'h0100})
            $display("FAIL single_00ff: got %h want %h", obs[3], {1'b1, 1'b0, 1'b0, 16'h0100});
        else n_pass++;
        pulse_one(16'hFFFF, 16'h0000, 1'b1);
        n_total++;
        if (obs[3] !== {1'b1, 1'b0, 1'b1, 16'h0000})
            $display("FAIL single_carry_chain: got %h want %h", obs[3], {1'b1, 1'b0, 1'b1, 16'h0000});
        else n_pass++;
    endtask

    task automatic test_ovf;
        out_ready = 1'b1;
        pulse_one(16'h7FFF, 16'h0001, 1'b0);
        n_total++;
        if (obs[3] !== {1'b1, OVF_ON, 1'b0, 16'h8000})
            $display("FAIL ovf_pos: got %h want %h", obs[3], {1'b1, OVF_ON, 1'b0, 16'h8000});
        else n_pass++;
        pulse_one(16'h8000, 16'h8000, 1'b0);
        n_total++;
        if (obs[3] !== {1'b1, OVF_ON, 1'b1, 16'h0000})
            $display("FAIL ovf_neg: got %h want %h", obs[3], {1'b1, OVF_ON, 1'b1, 16'h0000});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] sa [8];
        logic [15:0] sb [8];
        logic        sc [8];
        logic [18:0] exp;
        int nout = 0, first = -1, last = -1;
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom); sb[i] = 16'($urandom); sc[i] = 1'($urandom);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk); #1;
            if (vld_v[3]) begin
                if (nout < 8) begin
                    exp = ref_add(16, sa[nout], sb[nout], sc[nout]);
                    n_total++;
                    if (obs[3] !== exp) $display("FAIL stream_data[%0d]: got %h want %h", nout, obs[3], exp);
                    else n_pass++;
                end
                if (first < 0) first = cyc;
                last = cyc;
                nout++;
            end
            in_valid = (cyc < 8);
            if (cyc < 8) begin
                a = sa[cyc]; b = sb[cyc]; cin = sc[cyc];
            end
        end
        n_total++;
        if (nout != 8 || last - first != 7)
            $display("FAIL stream_count: got %0d results over %0d cycles want 8 over 8", nout, last - first + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [32:0] q [$];
        logic [32:0] e;
        logic [18:0] exp;
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        logic [15:0] held = '0;
        logic        hold = 1'b0;
        int accepted = 0, got = 0;
        for (int i = 0; i < 6; i++) begin
            pa[i] = 16'($urandom); pb[i] = 16'($urandom);
        end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (accepted < 6);
            if (accepted < 6) begin
                a = pa[accepted]; b = pb[accepted]; cin = 1'(accepted);
            end
            #1;
            if (cyc == 3) begin
                n_total++;
                if (accepted != 2 || rdy_v[3] !== 1'b0)
                    $display("FAIL bp_stall: got accepts=%0d in_ready=%b want 2 and 0", accepted, rdy_v[3]);
                else n_pass++;
            end
            if (hold) begin
                n_total++;
                if (sum16 !== held || vld_v[3] !== 1'b1)
                    $display("FAIL bp_hold: got %h/%b want %h/1", sum16, vld_v[3], held);
                else n_pass++;
            end
            hold = vld_v[3] && !out_ready;
            held = sum16;
            if (vld_v[3] && out_ready) begin
                e = q.pop_front();
                exp = ref_add(16, e[15:0], e[31:16], e[32]);
                n_total++;
                if (obs[3] !== exp) $display("FAIL bp_data[%0d]: got %h want %h", got, obs[3], exp);
                else n_pass++;
                got++;
            end
            if (in_valid && rdy_v[3]) begin
                q.push_back({cin, b, a});
                accepted++;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (got != 6) $display("FAIL bp_drain: got %0d results want 6", got); else n_pass++;
    endtask

    task automatic test_reset_flight;
        logic seen = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'h4321; b = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0; #1;
        n_total++;
        if (vld_v[3] !== 1'b1 || rdy_v[3] !== 1'b0)
            $display("FAIL flight_loaded: got valid=%b ready=%b want 1 and 0", vld_v[3], rdy_v[3]);
        else n_pass++;
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_total++;
        if (vld_v !== 4'h0) $display("FAIL flight_reset_valid: got %b want 0000", vld_v); else n_pass++;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk); #1;
        n_total++;
        if (rdy_v !== 4'hF) $display("FAIL flight_in_ready: got %b want 1111", rdy_v); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (vld_v !== 4'h0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL flight_discard: got stale output want none"); else n_pass++;
    endtask

    task automatic test_random;
        logic [32:0] q [$];
        logic [32:0] e;
        logic [18:0] exp;
        logic [18:0] held [4];
        logic        hold = 1'b0;
        logic        bad;
        int n_in = 0, n_out = 0, cycles = 0;
        while (n_out < 10000 && cycles < 60000) begin
            @(negedge clk);
            in_valid  = (n_in < 10000) && ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            #1;
            if (hold) begin
                bad = 1'b0;
                for (int k = 0; k < 4; k++) if (obs[k] !== held[k]) bad = 1'b1;
                n_total++;
                if (bad) $display("FAIL rand_hold: got %h want %h (WIDTH=16)", obs[3], held[3]); else n_pass++;
            end
            hold = vld_v[3] && !out_ready;
            for (int k = 0; k < 4; k++) held[k] = obs[k];
            if (vld_v[3] && out_ready) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL rand_extra: got unexpected result %h want none", obs[3]);
                end else begin
                    e = q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        exp = ref_add(wid[k], e[15:0], e[31:16], e[32]);
                        n_total++;
                        if (obs[k] !== exp)
                            $display("FAIL rand_w%0d[%0d]: got %h want %h", wid[k], n_out, obs[k], exp);
                        else n_pass++;
                    end
                end
                n_out++;
            end
            if (in_valid && rdy_v[3]) begin
                q.push_back({cin, b, a});
                n_in++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        n_total++;
        if (n_out != 10000 || q.size() != 0)
            $display("FAIL rand_complete: got %0d results (%0d pending) want 10000", n_out, q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ovf();
        test_back_to_back();
        test_backpressure();
        test_reset_flight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
